// File: rtl/i2s_rx.sv
// i2s_rx: slave-mode Philips I2S receiver.
// SCK/WS/SD come from an external master, are synchronised into clk, and are
// deserialised. Each stereo pair is presented on a valid/ready interface.
module i2s_rx #(
  parameter int DAT_WDTH    = 24,
  parameter int MAX_SLOT    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sck,
  input  logic                ws,
  input  logic                sd,
  output logic [DAT_WDTH-1:0] left_chan,
  output logic [DAT_WDTH-1:0] right_chan,
  output logic                valid,
  input  logic                ready,
  output logic                overrun
);

  localparam int CNT_W = (MAX_SLOT > 1) ? $clog2(MAX_SLOT) : 1;

  typedef enum logic [1:0] {UNSYNC, LEFT, RIGHT} state_t;

  // Write bit b at left-justified position idx (0 = MSB); indices past the word are dropped.
  function automatic logic [DAT_WDTH-1:0] insert_bit(input logic [DAT_WDTH-1:0] w,
                                                     input logic [CNT_W-1:0]    idx,
                                                     input logic                b);
    logic [DAT_WDTH-1:0] r;
    r = w;
    for (int i = 0; i < DAT_WDTH; i++) begin
      if (int'(idx) == i) r[DAT_WDTH-1-i] = b;
    end
    return r;
  endfunction

  // Bit counter increment that holds at MAX_SLOT-1 instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == CNT_W'(MAX_SLOT - 1)) return c;
    return c + CNT_W'(1);
  endfunction

  logic [SYNC_STAGES-1:0] sck_sync, ws_sync, sd_sync;
  logic                   sck_last;
  logic                   sck_rise;

  logic                   vld_p0;
  logic                   ws_p0, sd_p0;

  logic [CNT_W-1:0]       cnt_p1;
  logic [DAT_WDTH-1:0]    shreg_p1;
  logic [DAT_WDTH-1:0]    hold_left_p1;
  logic                   ws_last_p1;
  state_t                 state_q, state_n;

  logic                   ws_chg;
  logic [DAT_WDTH-1:0]    word_c;
  logic                   latch_left;
  logic                   publish;

  // ---- input synchronisers (asynchronous pins into clk domain) ----
  // Multi-flop synchronisers plus a delayed copy of sck for edge detection.
  always_ff @(posedge clk) begin
    sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
    ws_sync  <= {ws_sync[SYNC_STAGES-2:0], ws};
    sd_sync  <= {sd_sync[SYNC_STAGES-2:0], sd};
    sck_last <= sck_sync[SYNC_STAGES-1];
  end

  assign sck_rise = sck_sync[SYNC_STAGES-1] & ~sck_last;

  // ---- stage p0: sample ws/sd on each synchronised SCK rising edge ----
  // Capture ws and sd together; vld_p0 marks the cycle carrying a fresh bit.
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= sck_rise;
    ws_p0 <= ws_sync[SYNC_STAGES-1];
    sd_p0 <= sd_sync[SYNC_STAGES-1];
  end

  // A ws change marks the bit in sd_p0 as the last bit of the closing word.
  assign ws_chg = vld_p0 && (ws_p0 != ws_last_p1);
  assign word_c = insert_bit(shreg_p1, cnt_p1, sd_p0);

  // ---- stage p1: deserialise, frame, publish ----
  // Bit counter and shift register; both restart at each word boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1     <= '0;
      shreg_p1   <= '0;
      ws_last_p1 <= 1'b0;
    end else if (vld_p0) begin
      ws_last_p1 <= ws_p0;
      if (ws_chg) begin
        cnt_p1   <= '0;
        shreg_p1 <= '0;
      end else begin
        cnt_p1   <= sat_inc(cnt_p1);
        shreg_p1 <= word_c;
      end
    end
  end

  // Framing state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= UNSYNC;
    else     state_q <= state_n;
  end

  // Next-state logic: a ws edge closes the current word; the word closed in UNSYNC is dropped.
  always_comb begin
    state_n    = state_q;
    latch_left = 1'b0;
    publish    = 1'b0;
    if (ws_chg) begin
      case (state_q)
        UNSYNC: if (!ws_p0) state_n = LEFT;
        LEFT: if (ws_p0) begin
          latch_left = 1'b1;
          state_n    = RIGHT;
        end
        RIGHT: if (!ws_p0) begin
          publish = 1'b1;
          state_n = LEFT;
        end
        default: state_n = UNSYNC;
      endcase
    end
  end

  // Completed left word waits here until its right partner closes.
  always_ff @(posedge clk) begin
    if (latch_left) hold_left_p1 <= word_c;
  end

  // Output registers and valid/ready handshake; a publish over an unaccepted pair flags overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= 1'b0;
      overrun    <= 1'b0;
      left_chan  <= '0;
      right_chan <= '0;
    end else begin
      overrun <= 1'b0;
      if (publish) begin
        left_chan  <= hold_left_p1;
        right_chan <= word_c;
        valid      <= 1'b1;
        overrun    <= valid && !ready;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed bench for i2s_rx with an 8x clk/SCK ratio.
module tb_i2s_rx;

  logic        clk = 1'b0;
  logic        rst, sck, ws, sd, ready;
  logic [23:0] left_chan, right_chan;
  logic        valid, overrun;

  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0, vld_rise = 0, vld_fall = 0;
  logic vld_d = 1'b0;

  typedef struct {
    int          lbits;
    logic [31:0] lin;
    int          rbits;
    logic [31:0] rin;
    logic [23:0] el;
    logic [23:0] er;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  i2s_rx #(.DAT_WDTH(24), .MAX_SLOT(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sck(sck), .ws(ws), .sd(sd),
    .left_chan(left_chan), .right_chan(right_chan),
    .valid(valid), .ready(ready), .overrun(overrun)
  );

  // Event counters sampled shortly after each active edge.
  always @(posedge clk) begin
    #2;
    if (overrun) ovr_cnt++;
    if (valid && !vld_d) vld_rise++;
    if (!valid && vld_d) vld_fall++;
    vld_d = valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One SCK period (8 clk), starting at a negedge of clk. hist[k] = valid k+1 negedges after the rise.
  task automatic sck_cycle(input logic w, input logic d, input logic rpulse, output logic [3:0] hist);
    sck = 1'b0; ws = w; sd = d;
    repeat (4) @(negedge clk);
    sck = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      hist[k] = valid;
      if (rpulse && k == 2) ready = 1'b1;
      if (rpulse && k == 3) ready = 1'b0;
    end
  endtask

  // Philips word: the last bit goes out with the next channel's ws value.
  task automatic send_word(input logic ch, input logic [31:0] data, input int nbits,
                           input logic next_ch, input logic rpulse_last, output logic [3:0] hist);
    logic w;
    logic [3:0] h;
    h = '0;
    for (int i = 0; i < nbits; i++) begin
      w = (i == nbits - 1) ? next_ch : ch;
      sck_cycle(w, data[nbits-1-i], rpulse_last && (i == nbits - 1), h);
    end
    hist = h;
  endtask

  task automatic send_pair(input logic [31:0] l, input int lb, input logic [31:0] r, input int rb,
                           input logic rpulse, output logic [3:0] hist);
    logic [3:0] h;
    send_word(1'b0, l, lb, 1'b1, 1'b0, h);
    send_word(1'b1, r, rb, 1'b0, rpulse, hist);
  endtask

  task automatic accept(input string name);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk(name, 32'(valid), 32'd0);
  endtask

  initial begin
    logic [3:0] h;
    int r0, o0, f0;

    vecs[0] = '{32, 32'h12345600, 32, 32'hABCDEF00, 24'h123456, 24'hABCDEF};
    vecs[1] = '{16, 32'h00008001, 16, 32'h00007FFF, 24'h800100, 24'h7FFF00};
    vecs[2] = '{32, 32'h800000FF, 32, 32'h7FFFFF00, 24'h800000, 24'h7FFFFF};
    vecs[3] = '{24, 32'h00000001, 24, 32'h00FFFFFF, 24'h000001, 24'hFFFFFF};
    vecs[4] = '{20, 32'h000ABCDE, 20, 32'h00012345, 24'hABCDE0, 24'h123450};
    vecs[5] = '{32, 32'h0F0F0FFF, 16, 32'h0000C3A5, 24'h0F0F0F, 24'hC3A500};

    rst = 1'b1; sck = 1'b0; ws = 1'b0; sd = 1'b0; ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_left", 32'(left_chan), 32'd0);
    chk("rst_right", 32'(right_chan), 32'd0);
    rst = 1'b0;

    // Dummy right word; its closing 1->0 edge synchronises and the word is dropped.
    send_word(1'b1, 32'hDEADBEEF, 32, 1'b0, 1'b0, h);
    chk("dummy_dropped", 32'(vld_rise), 32'd0);

    // Table-driven framed captures.
    for (int i = 0; i < 6; i++) begin
      r0 = vld_rise; o0 = ovr_cnt;
      send_pair(vecs[i].lin, vecs[i].lbits, vecs[i].rin, vecs[i].rbits, 1'b0, h);
      chk($sformatf("vec%0d_latency", i), 32'(h), 32'b1000);
      chk($sformatf("vec%0d_valid", i), 32'(valid), 32'd1);
      chk($sformatf("vec%0d_left", i), 32'(left_chan), 32'(vecs[i].el));
      chk($sformatf("vec%0d_right", i), 32'(right_chan), 32'(vecs[i].er));
      chk($sformatf("vec%0d_overrun", i), 32'(ovr_cnt - o0), 32'd0);
      chk($sformatf("vec%0d_one_valid", i), 32'(vld_rise - r0), 32'd1);
      accept($sformatf("vec%0d_accept", i));
    end

    // Start mid-frame: reset covers the first half of a left slot.
    rst = 1'b1;
    send_word(1'b0, 32'h0000FFFF, 16, 1'b0, 1'b0, h);
    rst = 1'b0;
    r0 = vld_rise;
    send_word(1'b0, 32'h0000A5A5, 16, 1'b1, 1'b0, h);
    send_word(1'b1, 32'h11111111, 32, 1'b0, 1'b0, h);
    chk("mid_no_valid", 32'(vld_rise - r0), 32'd0);
    send_pair(32'h13579B00, 32, 32'h2468AC00, 32, 1'b0, h);
    chk("mid_valid", 32'(valid), 32'd1);
    chk("mid_left", 32'(left_chan), 32'h13579B);
    chk("mid_right", 32'(right_chan), 32'h2468AC);
    chk("mid_one_valid", 32'(vld_rise - r0), 32'd1);
    accept("mid_accept");

    // Backpressure across two frames.
    o0 = ovr_cnt;
    send_pair(32'h11111100, 32, 32'h22222200, 32, 1'b0, h);
    f0 = vld_fall;
    chk("bp_a_valid", 32'(valid), 32'd1);
    chk("bp_a_no_overrun", 32'(ovr_cnt - o0), 32'd0);
    send_pair(32'h33333300, 32, 32'h44444400, 32, 1'b0, h);
    chk("bp_overrun_pulse", 32'(ovr_cnt - o0), 32'd1);
    chk("bp_valid_held", 32'(vld_fall - f0), 32'd0);
    chk("bp_valid", 32'(valid), 32'd1);
    chk("bp_left", 32'(left_chan), 32'h333333);
    chk("bp_right", 32'(right_chan), 32'h444444);
    accept("bp_accept");

    // Accept in the exact publish cycle of the next pair.
    send_pair(32'h55555500, 32, 32'h66666600, 32, 1'b0, h);
    chk("col_c_valid", 32'(valid), 32'd1);
    o0 = ovr_cnt; f0 = vld_fall;
    send_pair(32'h77777700, 32, 32'h88888800, 32, 1'b1, h);
    chk("col_valid", 32'(valid), 32'd1);
    chk("col_left", 32'(left_chan), 32'h777777);
    chk("col_right", 32'(right_chan), 32'h888888);
    chk("col_no_overrun", 32'(ovr_cnt - o0), 32'd0);
    chk("col_valid_held", 32'(vld_fall - f0), 32'd0);
    accept("col_accept");

    // Reset with valid high, in the middle of a right slot.
    send_pair(32'h9ABCDE00, 32, 32'h0FEDCB00, 32, 1'b0, h);
    chk("rm_valid_before", 32'(valid), 32'd1);
    send_word(1'b0, 32'h12345678, 32, 1'b1, 1'b0, h);
    send_word(1'b1, 32'h0000FFFF, 16, 1'b1, 1'b0, h);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rm_valid", 32'(valid), 32'd0);
    chk("rm_overrun", 32'(overrun), 32'd0);
    chk("rm_left", 32'(left_chan), 32'd0);
    chk("rm_right", 32'(right_chan), 32'd0);
    r0 = vld_rise;
    send_word(1'b1, 32'h00001234, 16, 1'b0, 1'b0, h);
    chk("rm_no_valid", 32'(vld_rise - r0), 32'd0);
    send_pair(32'hCAFEBA00, 32, 32'h5EED0100, 32, 1'b0, h);
    chk("rm_new_valid", 32'(valid), 32'd1);
    chk("rm_new_left", 32'(left_chan), 32'hCAFEBA);
    chk("rm_new_right", 32'(right_chan), 32'h5EED01);
    chk("rm_one_valid", 32'(vld_rise - r0), 32'd1);
    accept("rm_accept");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
